// File: rtl/led_fader_if.sv
`default_nettype none
// ============================================================================
// Module   : led_fader_if
// Brief    : Level-in / PWM-out bundle between the blinky core and the LED pin.
// Revision : 1.0
// ============================================================================
interface led_fader_if #(
    parameter int PWM_BITS = 8
);
    logic                q_in;
    logic                led;
    logic [PWM_BITS-1:0] duty;
    logic                ramping;

    modport master (output q_in, input led, duty, ramping);
    modport slave  (input q_in, output led, duty, ramping);
endinterface
`default_nettype wire

// File: rtl/led_fader.sv
`default_nettype none
// ============================================================================
// Module   : led_fader
// Brief    : Turns an on/off level into a linear brightness ramp rendered as PWM.
// Revision : 1.0
// ============================================================================
module led_fader #(
    parameter int CLK_FREQ_HZ = 125_000_000,
    parameter int FADE_MS     = 250,
    parameter int PWM_BITS    = 8
) (
    input  wire logic  clk,
    input  wire logic  rst,
    led_fader_if.slave bus
);
    localparam int c_max_i     = (1 << PWM_BITS) - 1;
    localparam int c_raw_div   = (CLK_FREQ_HZ / 1000 * FADE_MS) / c_max_i;
    localparam int c_step_div  = (c_raw_div < 1) ? 1 : c_raw_div;
    localparam int c_presc_w   = ($clog2(c_step_div) < 1) ? 1 : $clog2(c_step_div);
    localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(c_step_div - 1);
    localparam logic [PWM_BITS-1:0]  c_max        = '1;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_UP   = 2'd1,
        ST_ON   = 2'd2,
        ST_DOWN = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nx;
    logic                  r_s1;
    logic                  r_s2;
    logic [PWM_BITS-1:0]   r_duty;
    logic [PWM_BITS-1:0]   w_duty_nx;
    logic [c_presc_w-1:0]  r_presc;
    logic [c_presc_w-1:0]  w_presc_nx;
    logic [PWM_BITS-1:0]   r_pwm_cnt;
    logic                  r_led;
    logic                  w_ramping;
    logic                  w_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_state   <= ST_OFF;
            r_duty    <= '0;
            r_presc   <= '0;
            r_pwm_cnt <= '0;
            r_led     <= 1'b0;
        end else begin
            r_s1      <= bus.q_in;
            r_s2      <= r_s1;
            r_state   <= w_state_nx;
            r_duty    <= w_duty_nx;
            r_presc   <= w_presc_nx;
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            r_led     <= (r_duty == c_max) | (r_pwm_cnt < r_duty);
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_duty_nx  = r_duty;
        w_presc_nx = '0;
        w_ramping  = (r_state == ST_UP) || (r_state == ST_DOWN);
        w_tick     = w_ramping && (r_presc == c_presc_last);

        // A target reversal wins over finishing the ramp and skips that step.
        case (r_state)
            ST_OFF: if (r_s2) w_state_nx = ST_UP;
            ST_ON:  if (!r_s2) w_state_nx = ST_DOWN;
            ST_UP: begin
                if (!r_s2)                w_state_nx = ST_DOWN;
                else if (r_duty == c_max) w_state_nx = ST_ON;
                else if (w_tick)          w_duty_nx  = r_duty + 1'b1;
            end
            ST_DOWN: begin
                if (r_s2)                 w_state_nx = ST_UP;
                else if (r_duty == '0)    w_state_nx = ST_OFF;
                else if (w_tick)          w_duty_nx  = r_duty - 1'b1;
            end
            default: w_state_nx = ST_OFF;
        endcase

        // The prescaler already advances on the edge that enters a ramp state,
        // so the first step lands step_div cycles after the synchronized input.
        if ((w_state_nx == ST_UP) || (w_state_nx == ST_DOWN)) begin
            w_presc_nx = (r_presc == c_presc_last) ? '0 : r_presc + 1'b1;
        end
    end

    assign bus.led     = r_led;
    assign bus.duty    = r_duty;
    assign bus.ramping = w_ramping;

endmodule
`default_nettype wire

// File: tb/tb_led_fader.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_fader
// Brief    : Scoreboard bench: stimulus queues timed duty/ramping events, monitor checks them.
// Revision : 1.0
// ============================================================================
module tb_led_fader;
    localparam int c_pwm_bits = 4;
    localparam int c_sd       = 66;
    localparam int c_m        = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;

    led_fader_if #(.PWM_BITS(c_pwm_bits)) bus ();

    led_fader #(
        .CLK_FREQ_HZ (1_000_000),
        .FADE_MS     (1),
        .PWM_BITS    (c_pwm_bits)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   cyc   = 0;
    logic rst_q = 1'b0;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    typedef struct {
        int at;
        int val;
    } ev_t;

    ev_t duty_q[$];
    ev_t ramp_q[$];
    int  n_checks = 0;
    int  n_err    = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_duty(input int at, input int val);
        ev_t e;
        e.at = at; e.val = val;
        duty_q.push_back(e);
    endtask

    task automatic push_ramp(input int at, input int val);
        ev_t e;
        e.at = at; e.val = val;
        ramp_q.push_back(e);
    endtask

    // ---------------- monitor ----------------
    logic        armed = 1'b0;
    int          prev_duty = 0;
    int          prev_ramp = 0;
    int          stable = 0;
    int          exp_hi;
    logic [15:0] led_hist = '0;
    ev_t         mon_e;

    always @(negedge clk) begin
        if (cyc >= 1) begin
            if (rst_q) begin
                check("rst_led", int'(bus.led), 0);
                check("rst_duty", int'(bus.duty), 0);
                check("rst_ramping", int'(bus.ramping), 0);
            end
            if (armed) begin
                if (int'(bus.duty) != prev_duty) begin
                    if (duty_q.size() == 0) begin
                        check("duty_unexpected_change", int'(bus.duty), prev_duty);
                    end else begin
                        mon_e = duty_q.pop_front();
                        check("duty_value", int'(bus.duty), mon_e.val);
                        check("duty_cycle", cyc, mon_e.at);
                    end
                end
                if (int'(bus.ramping) != prev_ramp) begin
                    if (ramp_q.size() == 0) begin
                        check("ramping_unexpected_change", int'(bus.ramping), prev_ramp);
                    end else begin
                        mon_e = ramp_q.pop_front();
                        check("ramping_value", int'(bus.ramping), mon_e.val);
                        check("ramping_cycle", cyc, mon_e.at);
                    end
                end
            end
            led_hist = {led_hist[14:0], bus.led};
            stable   = (armed && int'(bus.duty) == prev_duty) ? stable + 1 : 0;
            // led lags duty by one stage, so a 16-sample window needs 17 equal duty samples.
            if (stable >= 16 && (cyc % 16) == 0) begin
                exp_hi = (int'(bus.duty) == c_m) ? 16 : int'(bus.duty);
                check("pwm_window_high_count", $countones(led_hist), exp_hi);
            end
            prev_duty = int'(bus.duty);
            prev_ramp = int'(bus.ramping);
            armed     = 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic step_to(input int t);
        if (t > cyc) step(t - cyc);
    endtask

    task automatic wait_duty(input int v, input int bound, output int t);
        int found;
        found = 0;
        for (int i = 0; i < bound && found == 0; i++) begin
            step(1);
            if (int'(bus.duty) == v) found = 1;
        end
        check("wait_duty_reached", found, 1);
        t = cyc;
    endtask

    initial begin
        int k;
        int t;
        bus.q_in = 1'b1;
        rst      = 1'b1;

        // Reset held 3 cycles with q_in high, then a full rise.
        step(3);
        rst = 1'b0;
        k = cyc + 1;
        push_ramp(k + 2, 1);
        for (int i = 1; i <= c_m; i++) push_duty(k + c_sd + 1 + (i - 1) * c_sd, i);
        push_ramp(k + c_sd + 1 + (c_m - 1) * c_sd + 1, 0);
        step_to(k + c_sd * c_m + 40);

        // Full fall from ON.
        bus.q_in = 1'b0;
        k = cyc + 1;
        push_ramp(k + 2, 1);
        for (int i = 1; i <= c_m; i++) push_duty(k + c_sd + 1 + (i - 1) * c_sd, c_m - i);
        push_ramp(k + c_sd + 1 + (c_m - 1) * c_sd + 1, 0);
        step_to(k + c_sd * c_m + 20);

        // Rise to 7, then reverse; prescaler phase carries through the reversal.
        bus.q_in = 1'b1;
        k = cyc + 1;
        push_ramp(k + 2, 1);
        for (int i = 1; i <= 7; i++) push_duty(k + c_sd + 1 + (i - 1) * c_sd, i);
        wait_duty(7, 8 * c_sd + 20, t);
        bus.q_in = 1'b0;
        for (int i = 1; i <= 7; i++) push_duty(t + i * c_sd, 7 - i);
        push_ramp(t + 7 * c_sd + 1, 0);
        step_to(t + 7 * c_sd + 20);

        // One-cycle input pulse from OFF.
        bus.q_in = 1'b1;
        k = cyc + 1;
        step(1);
        bus.q_in = 1'b0;
        push_ramp(k + 2, 1);
        push_ramp(k + 4, 0);
        step(30);

        // Reset in the middle of a rise, then restart.
        bus.q_in = 1'b1;
        k = cyc + 1;
        push_ramp(k + 2, 1);
        for (int i = 1; i <= 9; i++) push_duty(k + c_sd + 1 + (i - 1) * c_sd, i);
        wait_duty(9, 10 * c_sd + 20, t);
        push_duty(t + 1, 0);
        push_ramp(t + 1, 0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        k = cyc + 1;
        push_ramp(k + 2, 1);
        push_duty(k + c_sd + 1, 1);
        push_duty(k + 2 * c_sd + 1, 2);
        step_to(k + 2 * c_sd + 6);

        check("duty_events_left", duty_q.size(), 0);
        check("ramping_events_left", ramp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout, required completion (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
